// File: rtl/press_fire_overlay.sv
// press_fire_overlay: title-screen "press fire" text overlay controller.
// Sits between the VGA scan counters and the color mapper. Converts the scan
// position into local text-map coordinates, registers the returned glyph
// pixel into a pixel-aligned text_on, and runs the blink / fire-acknowledge
// state machine that ends the title screen with a one-cycle game_start.
// Optional build macro: FIRE_DEBOUNCE_EN (fire must be seen high on three
// consecutive frame ticks before it counts as a press).

module press_fire_overlay #(
    parameter int TEXT_X0      = 292,
    parameter int TEXT_Y0      = 224,
    parameter int SCALE_SHIFT  = 1,
    parameter int BLINK_FRAMES = 30,
    parameter int ACK_FRAMES   = 4,
    parameter int ACK_FLASHES  = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       frame_clk,
    input  logic       fire,
    output logic [5:0] map_x,
    output logic [4:0] map_y,
    input  logic       map_pixel,
    output logic       text_on,
    output logic       game_start,
    output logic       busy
);

    localparam int BOX_W     = 56 << SCALE_SHIFT;
    localparam int BOX_H     = 32 << SCALE_SHIFT;
    localparam int FRAME_MAX = (BLINK_FRAMES > ACK_FRAMES) ? BLINK_FRAMES : ACK_FRAMES;
    localparam int FCW       = $clog2(FRAME_MAX + 1);
    localparam int FLW       = $clog2(2 * ACK_FLASHES + 1);

    localparam logic [FCW-1:0] BLINK_LAST = FCW'(BLINK_FRAMES - 1);
    localparam logic [FCW-1:0] ACK_LAST   = FCW'(ACK_FRAMES - 1);
    localparam logic [FLW-1:0] FLASH_LAST = FLW'(2 * ACK_FLASHES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        ACK,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             visible_q, visible_d;
    logic [FCW-1:0]   frameCnt_q, frameCnt_d;
    logic [FLW-1:0]   flashCnt_q, flashCnt_d;
    logic [1:0]       frameSync_q;
    logic             frameDly_q;
    logic [1:0]       fireSync_q;
    logic             textOn_q;
    logic             frameTick;
    logic             fireRise;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic             inBox;

    // Bring the vsync strobe and the fire button into the pixel clock domain
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frameSync_q <= '0;
            frameDly_q  <= 1'b0;
            fireSync_q  <= '0;
        end else begin
            frameSync_q <= {frameSync_q[0], frame_clk};
            frameDly_q  <= frameSync_q[1];
            fireSync_q  <= {fireSync_q[0], fire};
        end
    end

    assign frameTick = frameSync_q[1] & ~frameDly_q;

`ifdef FIRE_DEBOUNCE_EN
    logic [1:0] fireRun_q, fireRun_d;

    // Count consecutive frame ticks with fire held; the third one is the press
    always_comb begin
        fireRun_d = fireRun_q;
        fireRise  = 1'b0;
        if (frameTick) begin
            if (fireSync_q[1]) begin
                if (fireRun_q != 2'd3) begin
                    fireRun_d = fireRun_q + 2'd1;
                end
                if (fireRun_q == 2'd2) begin
                    fireRise = 1'b1;
                end
            end else begin
                fireRun_d = 2'd0;
            end
        end
    end

    // Hold the debounce run length between frame ticks
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fireRun_q <= 2'd0;
        end else begin
            fireRun_q <= fireRun_d;
        end
    end
`else
    logic fireDly_q;

    // Remember last synced fire level so a rising edge can be detected
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fireDly_q <= 1'b0;
        end else begin
            fireDly_q <= fireSync_q[1];
        end
    end

    assign fireRise = fireSync_q[1] & ~fireDly_q;
`endif

    // Translate the scan position into text-map space and clamp outside the box
    always_comb begin
        dx    = 11'($signed({1'b0, DrawX}) - TEXT_X0);
        dy    = 11'($signed({1'b0, DrawY}) - TEXT_Y0);
        inBox = !dx[10] && (dx[9:0] < 10'(BOX_W)) &&
                !dy[10] && (dy[9:0] < 10'(BOX_H));
        map_x = '0;
        map_y = '0;
        if (inBox) begin
            map_x = 6'(dx[9:0] >> SCALE_SHIFT);
            map_y = 5'(dy[9:0] >> SCALE_SHIFT);
        end
    end

    // State register together with the blink and flash counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            visible_q  <= 1'b1;
            frameCnt_q <= '0;
            flashCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            visible_q  <= visible_d;
            frameCnt_q <= frameCnt_d;
            flashCnt_q <= flashCnt_d;
        end
    end

    // Next-state logic: slow blink in SHOW, fast flash in ACK, enable drop aborts
    always_comb begin
        state_d    = state_q;
        visible_d  = visible_q;
        frameCnt_d = frameCnt_q;
        flashCnt_d = flashCnt_q;
        case (state_q)
            IDLE: begin
                visible_d  = 1'b1;
                frameCnt_d = '0;
                flashCnt_d = '0;
                state_d    = SHOW;
            end
            SHOW: begin
                if (fireRise) begin
                    state_d    = ACK;
                    visible_d  = 1'b1;
                    frameCnt_d = '0;
                    flashCnt_d = '0;
                end else if (frameTick) begin
                    if (frameCnt_q == BLINK_LAST) begin
                        visible_d  = ~visible_q;
                        frameCnt_d = '0;
                    end else begin
                        frameCnt_d = frameCnt_q + 1'b1;
                    end
                end
            end
            ACK: begin
                if (frameTick) begin
                    if (frameCnt_q == ACK_LAST) begin
                        visible_d  = ~visible_q;
                        frameCnt_d = '0;
                        flashCnt_d = flashCnt_q + 1'b1;
                        if (flashCnt_q == FLASH_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        frameCnt_d = frameCnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                visible_d  = 1'b1;
                frameCnt_d = '0;
                flashCnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!enable) begin
            state_d    = IDLE;
            visible_d  = 1'b1;
            frameCnt_d = '0;
            flashCnt_d = '0;
        end
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy       = (state_q != IDLE);
        game_start = (state_q == DONE);
    end

    // Register the glyph pixel so text_on lines up with the next pixel slot
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            textOn_q <= 1'b0;
        end else begin
            textOn_q <= enable && inBox && visible_q && map_pixel &&
                        ((state_q == SHOW) || (state_q == ACK));
        end
    end

    assign text_on = textOn_q;

endmodule

// File: tb/tb_press_fire_overlay.sv
// Self-checking bench for press_fire_overlay: constant vector table for the
// coordinate map, hand sequences for blink / acknowledge / abort / reset, and
// a randomized run compared against a tick-counting reference model.

module tb_press_fire_overlay;

    localparam int TEXT_X0      = 292;
    localparam int TEXT_Y0      = 224;
    localparam int SCALE_SHIFT  = 1;
    localparam int BLINK_FRAMES = 30;
    localparam int ACK_FRAMES   = 4;
    localparam int ACK_FLASHES  = 3;

    localparam int M_IDLE = 0;
    localparam int M_SHOW = 1;
    localparam int M_ACK  = 2;
    localparam int M_DONE = 3;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       enable;
    logic [9:0] drawX;
    logic [9:0] drawY;
    logic       frameClk;
    logic       fire;
    logic [5:0] mapX;
    logic [4:0] mapY;
    logic       mapPixel;
    logic       textOn;
    logic       gameStart;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int gsSeen   = 0;

    typedef struct {
        int       mode;
        int       showTicks;
        int       ackTicks;
        int       fireRun;
        bit [2:0] frameHist;
        bit [2:0] fireHist;
        bit       expText;
    } model_t;

    typedef struct {
        int x;
        int y;
        int mx;
        int my;
        bit txt;
    } vec_t;

    model_t mdl;
    vec_t   vecs[11];

    always #5 Clk = ~Clk;

    press_fire_overlay dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .enable     (enable),
        .DrawX      (drawX),
        .DrawY      (drawY),
        .frame_clk  (frameClk),
        .fire       (fire),
        .map_x      (mapX),
        .map_y      (mapY),
        .map_pixel  (mapPixel),
        .text_on    (textOn),
        .game_start (gameStart),
        .busy       (busy)
    );

    // Stand-in text map: a glyph pixel is lit where local x and y differ in parity
    always_comb mapPixel = mapX[0] ^ mapY[0];

    function automatic bit refInBox(input int x, input int y);
        int dx = x - TEXT_X0;
        int dy = y - TEXT_Y0;
        return (dx >= 0) && (dx < 56 * (1 << SCALE_SHIFT)) &&
               (dy >= 0) && (dy < 32 * (1 << SCALE_SHIFT));
    endfunction

    function automatic int refMapX(input int x, input int y);
        return refInBox(x, y) ? (x - TEXT_X0) / (1 << SCALE_SHIFT) : 0;
    endfunction

    function automatic int refMapY(input int x, input int y);
        return refInBox(x, y) ? (y - TEXT_Y0) / (1 << SCALE_SHIFT) : 0;
    endfunction

    function automatic bit refVisible(input model_t m);
        if (m.mode == M_SHOW) return ((m.showTicks / BLINK_FRAMES) % 2) == 0;
        if (m.mode == M_ACK)  return ((m.ackTicks / ACK_FRAMES) % 2) == 0;
        return 1'b1;
    endfunction

    function automatic model_t modelReset();
        model_t r;
        r.mode      = M_IDLE;
        r.showTicks = 0;
        r.ackTicks  = 0;
        r.fireRun   = 0;
        r.frameHist = '0;
        r.fireHist  = '0;
        r.expText   = 1'b0;
        return r;
    endfunction

    function automatic model_t modelStep(input model_t m, input bit en, input int x,
                                         input int y, input bit fclk, input bit fr);
        model_t n = m;
        bit tick;
        bit fireSynced;
        bit fireQual;
        bit glyph;
        tick       = m.frameHist[1] && !m.frameHist[2];
        fireSynced = m.fireHist[1];
`ifdef FIRE_DEBOUNCE_EN
        fireQual = tick && fireSynced && (m.fireRun == 2);
        if (tick) n.fireRun = fireSynced ? ((m.fireRun < 3) ? m.fireRun + 1 : 3) : 0;
`else
        fireQual = fireSynced && !m.fireHist[2];
`endif
        glyph     = ((refMapX(x, y) ^ refMapY(x, y)) & 1) == 1;
        n.expText = en && ((m.mode == M_SHOW) || (m.mode == M_ACK)) &&
                    refVisible(m) && refInBox(x, y) && glyph;
        n.frameHist = {m.frameHist[1:0], fclk};
        n.fireHist  = {m.fireHist[1:0], fr};
        if (!en) begin
            n.mode = M_IDLE;
        end else if (m.mode == M_IDLE) begin
            n.mode      = M_SHOW;
            n.showTicks = 0;
        end else if (m.mode == M_SHOW) begin
            if (fireQual) begin
                n.mode     = M_ACK;
                n.ackTicks = 0;
            end else if (tick) begin
                n.showTicks = m.showTicks + 1;
            end
        end else if (m.mode == M_ACK) begin
            if (tick) begin
                n.ackTicks = m.ackTicks + 1;
                if (n.ackTicks == ACK_FRAMES * 2 * ACK_FLASHES) n.mode = M_DONE;
            end
        end else begin
            n.mode = M_IDLE;
        end
        return n;
    endfunction

    // Reference model advances on the same clock and reset as the design
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) mdl <= modelReset();
        else          mdl <= modelStep(mdl, enable, int'(drawX), int'(drawY), frameClk, fire);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput();
        check("map_x",      int'(mapX), refMapX(int'(drawX), int'(drawY)));
        check("map_y",      int'(mapY), refMapY(int'(drawX), int'(drawY)));
        check("text_on",    int'(textOn), int'(mdl.expText));
        check("game_start", int'(gameStart), (mdl.mode == M_DONE) ? 1 : 0);
        check("busy",       int'(busy), (mdl.mode != M_IDLE) ? 1 : 0);
    endtask

    task automatic applyStimulus(input bit en, input bit fclk, input bit fr,
                                 input int x, input int y);
        @(posedge Clk);
        #2;
        enable   = en;
        frameClk = fclk;
        fire     = fr;
        drawX    = 10'(x);
        drawY    = 10'(y);
        @(negedge Clk);
        checkOutput();
        if (gameStart) gsSeen++;
    endtask

    task automatic pulseFrame(input bit en, input bit fr, input int x, input int y, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(en, 1'b1, fr, x, y);
            applyStimulus(en, 1'b1, fr, x, y);
            applyStimulus(en, 1'b0, fr, x, y);
            applyStimulus(en, 1'b0, fr, x, y);
        end
    endtask

    task automatic enterAck(input int x, input int y);
`ifdef FIRE_DEBOUNCE_EN
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, x, y);
        pulseFrame(1'b1, 1'b1, x, y, 3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, x, y);
`else
        applyStimulus(1'b1, 1'b1, 1'b1, x, y);
        applyStimulus(1'b1, 1'b1, 1'b1, x, y);
        applyStimulus(1'b1, 1'b0, 1'b0, x, y);
        applyStimulus(1'b1, 1'b0, 1'b0, x, y);
`endif
    endtask

    initial begin
        bit fc;
        bit fr;
        vecs[0]  = '{294, 228,  1,  2, 1'b1};
        vecs[1]  = '{292, 228,  0,  2, 1'b0};
        vecs[2]  = '{291, 240,  0,  0, 1'b0};
        vecs[3]  = '{404, 240,  0,  0, 1'b0};
        vecs[4]  = '{403, 240, 55,  8, 1'b1};
        vecs[5]  = '{292, 224,  0,  0, 1'b0};
        vecs[6]  = '{292, 287,  0, 31, 1'b1};
        vecs[7]  = '{292, 288,  0,  0, 1'b0};
        vecs[8]  = '{  0,   0,  0,  0, 1'b0};
        vecs[9]  = '{1023, 1023, 0, 0, 1'b0};
        vecs[10] = '{350, 250, 29, 13, 1'b0};

        Reset_n  = 1'b0;
        enable   = 1'b0;
        frameClk = 1'b0;
        fire     = 1'b0;
        drawX    = '0;
        drawY    = '0;

        // Reset state
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 294, 228);
        check("rst_text_on", int'(textOn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_game_start", int'(gameStart), 0);
        Reset_n = 1'b1;

        // Title screen on
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        check("show_busy", int'(busy), 1);

        // Coordinate map and pixel-aligned text_on from the vector table
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, vecs[i].x, vecs[i].y);
            check("tbl_map_x", int'(mapX), vecs[i].mx);
            check("tbl_map_y", int'(mapY), vecs[i].my);
            if (i > 0) check("tbl_text_on", int'(textOn), int'(vecs[i-1].txt));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        check("tbl_text_on_last", int'(textOn), int'(vecs[10].txt));

        // Slow blink: hidden after the 30th tick, shown again after the 60th
        for (int t = 1; t <= 60; t++) begin
            pulseFrame(1'b1, 1'b0, 294, 228, 1);
            if (t == 30) check("blink_t29_on", int'(textOn), 1);
            if (t == 31) check("blink_t30_off", int'(textOn), 0);
            if (t == 60) check("blink_t59_off", int'(textOn), 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        check("blink_t60_on", int'(textOn), 1);

`ifdef FIRE_DEBOUNCE_EN
        // Fire held across only two ticks must not start the acknowledge
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 294, 228);
        pulseFrame(1'b1, 1'b1, 294, 228, 2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        gsSeen = 0;
        pulseFrame(1'b1, 1'b0, 294, 228, 30);
        check("deb_two_ticks_no_start", gsSeen, 0);
        check("deb_two_ticks_busy", int'(busy), 1);
`endif

        // Fire press then 24 ticks: six toggles, one game_start, then idle
        gsSeen = 0;
        enterAck(294, 228);
        check("ack_busy", int'(busy), 1);
        for (int t = 1; t <= 24; t++) begin
            pulseFrame(1'b1, 1'b0, 294, 228, 1);
            if (t == 5)  check("ack_t4_off", int'(textOn), 0);
            if (t == 9)  check("ack_t8_on", int'(textOn), 1);
            if (t == 23) check("ack_no_early_start", gsSeen, 0);
        end
        check("ack_one_start", gsSeen, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        check("done_then_idle_busy", int'(busy), 0);
        check("done_then_idle_gs", int'(gameStart), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        check("start_single_cycle", gsSeen, 1);

        // Enable drops on the 10th acknowledge tick: abort without game_start
        gsSeen = 0;
        enterAck(294, 228);
        pulseFrame(1'b1, 1'b0, 294, 228, 9);
        applyStimulus(1'b1, 1'b1, 1'b0, 294, 228);
        applyStimulus(1'b1, 1'b1, 1'b0, 294, 228);
        applyStimulus(1'b0, 1'b0, 1'b0, 294, 228);
        applyStimulus(1'b0, 1'b0, 1'b0, 294, 228);
        check("abort_busy", int'(busy), 0);
        check("abort_text_on", int'(textOn), 0);
        pulseFrame(1'b0, 1'b0, 294, 228, 30);
        check("abort_no_start", gsSeen, 0);

        // Asynchronous reset in the middle of the acknowledge flash
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        enterAck(294, 228);
        pulseFrame(1'b1, 1'b0, 294, 228, 1);
        check("pre_reset_text_on", int'(textOn), 1);
        Reset_n = 1'b0;
        #1;
        check("async_rst_text_on", int'(textOn), 0);
        check("async_rst_game_start", int'(gameStart), 0);
        check("async_rst_busy", int'(busy), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 294, 228);
        Reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 294, 228);
        check("post_rst_idle", int'(busy), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        applyStimulus(1'b1, 1'b0, 1'b0, 294, 228);
        check("post_rst_visible", int'(textOn), 1);

        // Randomized traffic against the reference model
        fc = 1'b0;
        fr = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0)  fc = ~fc;
            if ($urandom_range(0, 19) == 0) fr = ~fr;
            applyStimulus(($urandom_range(0, 99) < 97) ? 1'b1 : 1'b0, fc, fr,
                          int'($urandom_range(270, 420)), int'($urandom_range(200, 300)));
            if (!Reset_n) begin
                Reset_n = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                Reset_n = 1'b0;
                #1;
                checkOutput();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/press_fire_overlay.md
Name: press_fire_overlay

Overview:
Title-screen text overlay controller between the VGA sync/counter stage and the color mapper. Maps the current scan position into the 56x32 local coordinate space of the press-fire text map and drives its X/Y inputs. Registers the returned glyph pixel into a pixel-aligned text_on. Runs the blink / fire-acknowledge state machine and issues a one-cycle game_start pulse.

Parameters:
TEXT_X0, 292, screen X of text box left edge
TEXT_Y0, 224, screen Y of text box top edge
SCALE_SHIFT, 1, log2 magnification; box is (56<<S) x (32<<S) screen pixels; legal 0..2
BLINK_FRAMES, 30, frame ticks per visibility toggle in SHOW
ACK_FRAMES, 4, frame ticks per visibility toggle in ACK
ACK_FLASHES, 3, full on/off flashes in ACK before DONE

Ports:
Clk  in  1  pixel-domain clock
Reset_n  in  1  asynchronous, active-low reset
enable  in  1  title screen active (synchronous to Clk)
DrawX  in  10  current scan X
DrawY  in  10  current scan Y
frame_clk  in  1  vsync-rate strobe (asynchronous to Clk)
fire  in  1  raw fire button, active-high (asynchronous)
map_x  out  6  local X to text map
map_y  out  5  local Y to text map
map_pixel  in  1  glyph pixel returned combinationally by text map
text_on  out  1  draw text color at the pixel presented one cycle earlier
game_start  out  1  one-cycle pulse, title screen finished
busy  out  1  high in SHOW, ACK or DONE

Behaviour:
- Reset (Reset_n low, asynchronous): state IDLE; visible=1; frame and flash counters 0; sync flops 0; text_on=0, game_start=0, busy=0.
- Synchronizers: frame_clk and fire each pass through 2 flops. frame_tick = one-cycle pulse on the synced frame_clk rising edge. fire_rise = one-cycle pulse on the synced fire rising edge.
- Coordinate map (combinational):
  - dx=DrawX-TEXT_X0, dy=DrawY-TEXT_Y0, computed 11-bit signed.
  - in_box = dx>=0 && dx<(56<<S) && dy>=0 && dy<(32<<S).
  - map_x=dx>>S, map_y=dy>>S when in_box; otherwise map_x=0, map_y=0.
- Output stage (registered, 1 cycle latency): text_on <= in_box && visible && map_pixel && (state is SHOW or ACK). The bench accounts for the 1-cycle DrawX/DrawY alignment.
- FSM:
  - IDLE: visible=1, counters 0. enable=1 -> SHOW.
  - SHOW: each frame_tick increments frame_cnt. When frame_cnt reaches BLINK_FRAMES-1 on a tick, visible toggles and frame_cnt clears. fire_rise -> ACK with visible=1, frame_cnt=0, flash_cnt=0.
  - ACK: visibility toggles every ACK_FRAMES ticks. flash_cnt increments on each toggle. The toggle that makes flash_cnt==2*ACK_FLASHES moves to DONE. fire_rise is ignored.
  - DONE: game_start=1 for exactly this cycle -> IDLE.
  - enable=0 in any state -> IDLE next cycle. No game_start is issued and text_on=0 from the following cycle.
- Simultaneous events:
  - fire_rise and frame_tick in the same cycle in SHOW: ACK wins; the tick is not counted.
  - enable fall and fire_rise in the same cycle: IDLE wins.
- Counters are sized to hold max(BLINK_FRAMES, ACK_FRAMES) and 2*ACK_FLASHES. They never wrap in normal operation.
- DrawX/DrawY outside the 640x480 visible area need no special handling beyond in_box.

Optional Feature:
FIRE_DEBOUNCE_EN
- Defined: fire_rise qualifies only after the synced fire has been sampled high on 3 consecutive frame_ticks, counted from the last low sample. One qualified press per hold; fire must go low before the next press qualifies.
- Undefined: the raw synced rising edge is used directly.

Test Plan:
- Reset_n low mid-ACK -> text_on=0, game_start=0, busy=0 immediately. After release, state IDLE and visible=1.
- enable=1, real text map attached, defaults, DrawX=294, DrawY=228 -> map_x=1, map_y=2; text_on=1 one cycle later ('S' row 2 bit 6 set). DrawX=292 -> text_on=0.
- DrawX=291 or DrawX=404, DrawY=240 -> map_x=0, map_y=0, text_on=0 (box edges: 292 inclusive, 404 exclusive).
- SHOW with 60 frame_ticks -> visible toggles after tick 30 and tick 60; text_on is suppressed during ticks 31..60 over glyph pixels.
- fire pulse in SHOW, then 24 frame_ticks -> 6 toggles. game_start is high for exactly 1 cycle after the 24th tick, then busy=0.
- enable drops on the 10th tick of ACK -> IDLE; no game_start. With FIRE_DEBOUNCE_EN, fire held for 2 ticks -> stays in SHOW; held for 3 ticks -> enters ACK.
